ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 101 ++++++++++
 tb/tb_ram_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: valid/ready front end for a single-port registered-read RAM; RAM_CTRL_INIT_EN adds a power-up fill sweep
module ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);
`ifdef RAM_CTRL_INIT_EN
  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;
  logic [ADDR_WIDTH-1:0] init_cnt;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif
  state_t state, state_nx;
  logic rd_pend;
  logic [1:0] rsp_count;
  logic wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic acc, push, pop;

  assign acc = req_valid && req_ready;
  assign push = rd_pend;
  assign pop = rsp_valid && rsp_ready;
  assign rsp_valid = rsp_count != 2'd0;
  assign rsp_rdata = rsp_valid ? fifo[rd_ptr] : '0;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

`ifdef RAM_CTRL_INIT_EN
  // next state: fill sweep runs once after reset, then serve requests
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = INIT;
    else if (state == INIT && init_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nx = RUN;
  end

  // sweep address counter, restarts from 0 on every reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) init_cnt <= '0;
    else if (state == INIT) init_cnt <= init_cnt + 1'b1;
`else
  // next state: go straight to serving requests
  always_comb state_nx = (state == IDLE) ? RUN : state;
`endif

  // outputs: credit-limited ready so at most two reads are ever in flight or queued
  always_comb begin
    req_ready = (state == RUN) && (3'(rsp_count) + 3'(rd_pend) < 3'd2);
    ram_w_en = req_valid && req_ready && req_we;
    ram_addr = req_addr;
    ram_data_in = (state == RUN) ? req_wdata : INIT_VALUE;
    busy = 1'b0;
`ifdef RAM_CTRL_INIT_EN
    if (state == INIT) begin
      busy = 1'b1;
      ram_w_en = 1'b1;
      ram_addr = init_cnt;
    end
`endif
  end

  // read pipeline flag and response fifo pointers/occupancy
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rsp_count <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      rd_pend <= acc && !req_we;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      rsp_count <= rsp_count + 2'(push) - 2'(pop);
    end

  // response fifo storage captures the registered RAM output one cycle after a read
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= ram_data_out;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && rsp_count == 2'd2))
    else $error("ram_ctrl response fifo overflow");
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: directed and randomized bench for ram_ctrl against a queue/array reference model
module tb_ram_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [DW-1:0] IV = 32'hA5A5_0F0F;
`ifdef RAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, ram_w_en, busy;
  logic [DW-1:0] rsp_rdata, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] q_dat [$];
  int q_cyc [$];
  int cyc = 0, wait_n = 0, checks = 0, failures = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_VALUE(IV)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  always @(posedge clk) begin
    if (ram_w_en) ram[ram_addr] <= ram_data_in;
    ram_data_out <= ram[ram_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rr, output logic dut_acc);
    logic m_ready, m_valid, m_acc, m_busy;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
    #1;
    m_ready = (wait_n == 0) && (q_dat.size() < 2);
    m_valid = (q_dat.size() > 0) && (q_cyc[0] + 2 <= cyc);
    m_acc = v && m_ready;
    m_busy = INIT_EN && wait_n >= 1 && wait_n <= DEPTH;
    dut_acc = v && req_ready;
    check("req_ready", 64'(req_ready), 64'(m_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    if (m_valid) check("rsp_rdata", 64'(rsp_rdata), 64'(q_dat[0]));
    check("busy", 64'(busy), 64'(m_busy));
    if (m_busy) begin
      check("init_we", 64'(ram_w_en), 64'd1);
      check("init_addr", 64'(ram_addr), 64'(DEPTH - wait_n));
      check("init_data", 64'(ram_data_in), 64'(IV));
    end else check("ram_w_en", 64'(ram_w_en), 64'(m_acc && we));
    if (m_acc) check("ram_addr", 64'(ram_addr), 64'(a));
    if (m_acc && we) check("ram_data_in", 64'(ram_data_in), 64'(d));
    @(posedge clk);
    if (m_valid && rr) begin
      void'(q_dat.pop_front());
      void'(q_cyc.pop_front());
    end
    if (m_acc && we) mdl[a] = d;
    else if (m_acc) begin
      q_dat.push_back(mdl[a]);
      q_cyc.push_back(cyc);
    end
    if (wait_n > 0) wait_n--;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    logic x;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rr, x);
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    logic acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, we, a, d, rr, acc);
    if (!acc) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_dat.size() > 0; i++) idle(1, 1'b1);
    idle(1, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ram_w_en", 64'(ram_w_en), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    q_dat.delete();
    q_cyc.delete();
    if (INIT_EN) for (int i = 0; i < DEPTH; i++) mdl[i] = IV;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_n = INIT_EN ? DEPTH + 1 : 1;
  endtask

  task automatic wait_run();
    for (int i = 0; i < DEPTH + 4 && wait_n > 0; i++) idle(1, 1'b1);
  endtask

  initial begin
    logic acc;
    int n_acc;
    @(negedge clk);
    do_reset();
    wait_run();
    if (INIT_EN) begin
      issue(1'b0, 4'd9, '0, 1'b1);
      drain();
    end else
      for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), $urandom, 1'b1);
    // write then read the same address on the next cycle
    issue(1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1);
    issue(1'b0, 4'd5, '0, 1'b1);
    idle(1, 1'b1);
    check("rd_after_wr_valid", 64'(rsp_valid), 64'd1);
    check("rd_after_wr_data", 64'(rsp_rdata), 64'hDEAD_BEEF);
    drain();
    // three reads with the consumer stalled: third must wait for credit
    issue(1'b1, 4'd1, 32'h11, 1'b1);
    issue(1'b1, 4'd2, 32'h22, 1'b1);
    issue(1'b1, 4'd3, 32'h33, 1'b1);
    drain();
    issue(1'b0, 4'd1, '0, 1'b0);
    issue(1'b0, 4'd2, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 4'd3, '0, 1'b0, acc);
      check("third_read_held", 64'(acc), 64'd0);
    end
    check("head_is_first", 64'(rsp_rdata), 64'h11);
    issue(1'b0, 4'd3, '0, 1'b1);
    drain();
    // single queued response held under back-pressure
    issue(1'b0, 4'd7, '0, 1'b0);
    idle(12, 1'b0);
    drain();
    // sustained reads accept two of every three cycles
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, AW'($urandom_range(0, DEPTH - 1)), '0, 1'b1, acc);
      n_acc += int'(acc);
    end
    check("read_rate", 64'(n_acc), 64'd20);
    drain();
    // reset with one read pending and one response queued
    issue(1'b0, 4'd4, '0, 1'b0);
    issue(1'b0, 4'd6, '0, 1'b0);
    do_reset();
    wait_run();
    idle(5, 1'b1);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), AW'($urandom_range(0, DEPTH - 1)), $urandom,
           1'($urandom_range(0, 3) != 0), acc);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
